// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED pixel path.
// RGB565 field layout, panel geometry and the fade state encoding.
package oled_pkg;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    localparam int R_W = R_MSB - R_LSB + 1;
    localparam int G_W = G_MSB - G_LSB + 1;
    localparam int B_W = B_MSB - B_LSB + 1;
    localparam int PIX_W = R_W + G_W + B_W;

    localparam int OLED_W = 96;
    localparam int OLED_H = 64;
    localparam int FRAME_PIXELS = OLED_W * OLED_H;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_t;

    // Width of a source code that also has room for the blank code.
    function automatic int sel_width(input int num_src);
        return $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/pixel_fader.sv
// Combinational RGB565 brightness scaler.
// Each channel becomes (chan * level) >> log2(FADE_STEPS), truncated.
module pixel_fader
    import oled_pkg::*;
#(
    parameter int FADE_STEPS = 4,
    localparam int LVL_W = $clog2(FADE_STEPS + 1)
) (
    input  logic [PIX_W-1:0] pix_in,
    input  logic [LVL_W-1:0] level,
    output logic [PIX_W-1:0] pix_out
);

    localparam int SH = $clog2(FADE_STEPS);
    localparam int RP_W = R_W + SH + 1;
    localparam int GP_W = G_W + SH + 1;
    localparam int BP_W = B_W + SH + 1;

    logic [RP_W-1:0] r_p;
    logic [GP_W-1:0] g_p;
    logic [BP_W-1:0] b_p;
    logic [R_W-1:0]  r_s;
    logic [G_W-1:0]  g_s;
    logic [B_W-1:0]  b_s;

    // Products are wide enough for chan * FADE_STEPS, so nothing wraps.
    always_comb begin
        r_p = RP_W'(pix_in[R_MSB:R_LSB]) * RP_W'(level);
        g_p = GP_W'(pix_in[G_MSB:G_LSB]) * GP_W'(level);
        b_p = BP_W'(pix_in[B_MSB:B_LSB]) * BP_W'(level);
        r_s = R_W'(r_p >> SH);
        g_s = G_W'(g_p >> SH);
        b_s = B_W'(b_p >> SH);
        pix_out = {r_s, g_s, b_s};
    end

endmodule

// File: rtl/oled_source_mux.sv
// N-source pixel selector for the OLED path with debounced,
// frame-aligned switching and an optional fade crossover.
module oled_source_mux
    import oled_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int PIXEL_W = 16,
    parameter int IDX_W = 13,
    parameter int DEFAULT_SRC = NUM_SRC - 1,
    parameter int DEB_CYCLES = 8,
    parameter int FADE_EN = 1,
    parameter int FADE_STEPS = 4,
    localparam int SEL_W = sel_width(NUM_SRC)
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [IDX_W-1:0]           pixel_index,
    input  logic [NUM_SRC*PIXEL_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]         sel_req,
    input  logic                       blank_req,
    output logic [PIXEL_W-1:0]         pixel_data,
    output logic [SEL_W-1:0]           active_src,
    output logic                       switching
);

    localparam int LVL_W = $clog2(FADE_STEPS + 1);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    localparam logic [SEL_W-1:0] DEF_CODE   = SEL_W'(DEFAULT_SRC);
    localparam logic [SEL_W-1:0] BLANK_CODE = SEL_W'(NUM_SRC);
    localparam logic [LVL_W-1:0] LVL_MAX    = LVL_W'(FADE_STEPS);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W:0]   HELD_REQ   = (CNT_W+1)'(DEB_CYCLES);

    logic [NUM_SRC-1:0] sel_s1;
    logic [NUM_SRC-1:0] sel_s2;
    logic               blank_s1;
    logic               blank_s2;

    logic [SEL_W-1:0]   raw_tgt;
    logic [SEL_W-1:0]   prev_raw;
    logic [CNT_W-1:0]   deb_cnt;
    logic [CNT_W:0]     held;
    logic [SEL_W-1:0]   deb_tgt;

    logic [IDX_W-1:0]   prev_idx;
    logic               frame_start;

    fade_state_t        state;
    logic [LVL_W-1:0]   level;

    logic [PIXEL_W-1:0] sel_pix;
    logic [PIXEL_W-1:0] faded_pix;

    // Two-flop synchronisers for the asynchronous request inputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sel_s1   <= '0;
            sel_s2   <= '0;
            blank_s1 <= 1'b0;
            blank_s2 <= 1'b0;
        end else begin
            sel_s1   <= sel_req;
            sel_s2   <= sel_s1;
            blank_s1 <= blank_req;
            blank_s2 <= blank_s1;
        end
    end

    // Priority encode: lowest set request wins, then blank, then default.
    always_comb begin
        raw_tgt = blank_s2 ? BLANK_CODE : DEF_CODE;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (sel_s2[k]) raw_tgt = SEL_W'(k);
        end
    end

    // Consecutive cycles the raw target has been stable, this one included.
    always_comb begin
        if (raw_tgt != prev_raw) held = (CNT_W+1)'(1);
        else                     held = {1'b0, deb_cnt} + (CNT_W+1)'(2);
    end

    // Debounce: accept the raw target once it has been held long enough.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prev_raw <= DEF_CODE;
            deb_cnt  <= '0;
            deb_tgt  <= DEF_CODE;
        end else begin
            prev_raw <= raw_tgt;
            if (raw_tgt != prev_raw)   deb_cnt <= '0;
            else if (deb_cnt != CNT_MAX) deb_cnt <= deb_cnt + 1'b1;
            if (held >= HELD_REQ) deb_tgt <= raw_tgt;
        end
    end

    // Track the previous index to spot the wrap to pixel 0.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) prev_idx <= '0;
        else         prev_idx <= pixel_index;
    end

    assign frame_start = (pixel_index == '0) && (prev_idx != '0);

    // Source/fade sequencer; only moves on a frame boundary.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= SHOW;
            level      <= LVL_MAX;
            active_src <= DEF_CODE;
        end else if (frame_start) begin
            unique case (state)
                SHOW: begin
                    if (deb_tgt != active_src) begin
                        if (FADE_EN == 0) begin
                            active_src <= deb_tgt;
                        end else begin
                            level <= level - 1'b1;
                            state <= FADE_OUT;
                        end
                    end
                end
                FADE_OUT: begin
                    if (deb_tgt == active_src) begin
                        state <= FADE_IN;
                    end else if (level != '0) begin
                        level <= level - 1'b1;
                    end else begin
                        active_src <= deb_tgt;
                        state      <= FADE_IN;
                    end
                end
                FADE_IN: begin
                    if (deb_tgt != active_src) begin
                        state <= FADE_OUT;
                    end else if (level >= LVL_MAX - 1'b1) begin
                        level <= LVL_MAX;
                        state <= SHOW;
                    end else begin
                        level <= level + 1'b1;
                    end
                end
                default: begin
                    state <= SHOW;
                    level <= LVL_MAX;
                end
            endcase
        end
    end

    assign switching = (state != SHOW);

    // Pick the active source slice; the blank code yields black.
    always_comb begin
        sel_pix = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (active_src == SEL_W'(k)) sel_pix = src_data[k*PIXEL_W +: PIXEL_W];
        end
    end

    pixel_fader #(
        .FADE_STEPS (FADE_STEPS)
    ) u_fader (
        .pix_in  (sel_pix),
        .level   (level),
        .pix_out (faded_pix)
    );

    // Output register: one cycle from index/data to pixel_data.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) pixel_data <= '0;
        else         pixel_data <= faded_pix;
    end

endmodule

// File: tb/tb_oled_source_mux.sv
// Directed bench for oled_source_mux: fading and hard-switch
// instances share stimulus; short synthetic frames keep runs small.
module tb_oled_source_mux;

    localparam int FRAME_LEN = 32;

    logic        clock;
    logic        resetn;
    logic [12:0] pixel_index;
    logic [63:0] src_data;
    logic [3:0]  sel_req;
    logic        blank_req;

    logic [15:0] pix_a;
    logic [2:0]  act_a;
    logic        sw_a;
    logic [15:0] pix_b;
    logic [2:0]  act_b;
    logic        sw_b;

    int n_tests = 0;
    int n_fail = 0;
    bit run_idx = 0;

    oled_source_mux #(
        .FADE_EN (1)
    ) u_fade (
        .clock       (clock),
        .resetn      (resetn),
        .pixel_index (pixel_index),
        .src_data    (src_data),
        .sel_req     (sel_req),
        .blank_req   (blank_req),
        .pixel_data  (pix_a),
        .active_src  (act_a),
        .switching   (sw_a)
    );

    oled_source_mux #(
        .FADE_EN (0)
    ) u_hard (
        .clock       (clock),
        .resetn      (resetn),
        .pixel_index (pixel_index),
        .src_data    (src_data),
        .sel_req     (sel_req),
        .blank_req   (blank_req),
        .pixel_data  (pix_b),
        .active_src  (act_b),
        .switching   (sw_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  sel;
        logic [2:0]  act;
        logic        sw;
        logic [15:0] pix;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (run_idx) begin
            if (pixel_index == 13'(FRAME_LEN - 1)) pixel_index = '0;
            else pixel_index = pixel_index + 13'd1;
        end
    endtask

    task automatic wait_wrap(input string tag);
        int n;
        n = 0;
        while (pixel_index != '0 && n < FRAME_LEN + 2) begin
            tick();
            n++;
        end
        if (pixel_index != '0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no frame wrap within %0d cycles", tag, n);
        end
    endtask

    // Run up to the wrap, through the frame_start edge, and one more
    // edge so pixel_data reflects the post-switch state.
    task automatic next_frame(input string tag);
        wait_wrap(tag);
        tick();
        tick();
    endtask

    initial begin
        vecs[0]  = '{4'b0110, 3'd3, 1'b1, 16'hBDF7};
        vecs[1]  = '{4'b0110, 3'd3, 1'b1, 16'h7BEF};
        vecs[2]  = '{4'b0110, 3'd3, 1'b1, 16'h39E7};
        vecs[3]  = '{4'b0110, 3'd3, 1'b1, 16'h0000};
        vecs[4]  = '{4'b0110, 3'd1, 1'b1, 16'h0000};
        vecs[5]  = '{4'b0110, 3'd1, 1'b1, 16'h2104};
        vecs[6]  = '{4'b0110, 3'd1, 1'b1, 16'h4208};
        vecs[7]  = '{4'b0110, 3'd1, 1'b1, 16'h630C};
        vecs[8]  = '{4'b0110, 3'd1, 1'b0, 16'h8410};
        vecs[9]  = '{4'b0000, 3'd1, 1'b1, 16'h630C};
        vecs[10] = '{4'b0000, 3'd1, 1'b1, 16'h4208};
        vecs[11] = '{4'b0110, 3'd1, 1'b1, 16'h4208};
        vecs[12] = '{4'b0110, 3'd1, 1'b1, 16'h630C};
        vecs[13] = '{4'b0110, 3'd1, 1'b0, 16'h8410};

        resetn      = 1'b0;
        pixel_index = '0;
        sel_req     = '0;
        blank_req   = 1'b0;
        src_data    = {16'hF800, 16'h0F0F, 16'h8410, 16'h1234};

        repeat (3) @(posedge clock);
        #1;
        check("reset_pix", pix_a, 16'h0000);
        check("reset_act", act_a, 3'd3);
        check("reset_sw", sw_a, 1'b0);
        check("reset_pix_hard", pix_b, 16'h0000);

        resetn  = 1'b1;
        run_idx = 1;
        tick();
        check("post_reset_pix", pix_a, 16'hF800);
        check("post_reset_act", act_a, 3'd3);
        check("post_reset_sw", sw_a, 1'b0);

        src_data[63:48] = 16'hFFFF;
        tick();
        tick();
        check("src3_white", pix_a, 16'hFFFF);

        for (int i = 0; i < 14; i++) begin
            sel_req = vecs[i].sel;
            next_frame($sformatf("vec%0d", i));
            check($sformatf("vec%0d_act", i), act_a, vecs[i].act);
            check($sformatf("vec%0d_sw", i), sw_a, vecs[i].sw);
            check($sformatf("vec%0d_pix", i), pix_a, vecs[i].pix);
        end

        sel_req = 4'b0111;
        repeat (5) tick();
        sel_req = 4'b0110;
        repeat (12) tick();
        check("glitch_act_mid", act_a, 3'd1);
        check("glitch_sw_mid", sw_a, 1'b0);
        next_frame("glitch");
        check("glitch_act", act_a, 3'd1);
        check("glitch_sw", sw_a, 1'b0);
        check("glitch_pix", pix_a, 16'h8410);

        sel_req   = 4'b0000;
        blank_req = 1'b1;
        repeat (15) tick();
        check("blank_mid_act", act_b, 3'd1);
        check("blank_mid_pix", pix_b, 16'h8410);
        wait_wrap("blank");
        tick();
        check("blank_edge_act", act_b, 3'd4);
        check("blank_edge_pix", pix_b, 16'h8410);
        check("blank_edge_sw", sw_b, 1'b0);
        tick();
        check("blank_pix", pix_b, 16'h0000);
        check("blank_fade_pix", pix_a, 16'h630C);
        check("blank_fade_sw", sw_a, 1'b1);

        next_frame("fo2");
        next_frame("fo1");
        next_frame("fo0");
        check("fo0_act", act_a, 3'd1);
        next_frame("fi0");
        check("fi0_act", act_a, 3'd4);
        check("fi0_pix", pix_a, 16'h0000);
        next_frame("fi1");
        check("fi1_sw", sw_a, 1'b1);

        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_pix", pix_a, 16'h0000);
        check("async_rst_act", act_a, 3'd3);
        check("async_rst_sw", sw_a, 1'b0);
        check("async_rst_act_hard", act_b, 3'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_source_mux.md
Name: oled_source_mux

Overview:
- Parametrised N-source pixel selector for the 96x64 RGB565 OLED path. Generalises the fixed switch-priority border/colour-bar mux.
- Adds input synchronisation and debounce, tear-free switching aligned to frame start, and an optional per-frame fade-out/fade-in crossover.
- Sits between the pixel generators (border, colour bar, future sources) and the OLED driver's pixel_data input.

Parameters:
- NUM_SRC, 4, number of pixel sources; sel_req[0] has highest priority.
- PIXEL_W, 16, pixel width in RGB565 (R[15:11] G[10:5] B[4:0]).
- IDX_W, 13, pixel_index width.
- DEFAULT_SRC, NUM_SRC-1, source shown when no request bit is set.
- DEB_CYCLES, 8, cycles a raw target must be held before it is accepted; must be >= 1.
- FADE_EN, 1, 1 = fade on switch, 0 = hard switch at frame start.
- FADE_STEPS, 4, fade levels; power of 2, >= 2.

Ports:
- clock  in  1  system clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- pixel_index  in  IDX_W  current OLED pixel index from the driver.
- src_data  in  NUM_SRC*PIXEL_W  packed source pixels; source k at [k*PIXEL_W +: PIXEL_W].
- sel_req  in  NUM_SRC  asynchronous switch requests.
- blank_req  in  1  asynchronous request for black output.
- pixel_data  out  PIXEL_W  registered output pixel.
- active_src  out  SEL_W  currently displayed target. SEL_W = $clog2(NUM_SRC+1); code NUM_SRC = blank.
- switching  out  1  high whenever state != SHOW.

Behaviour:
- Reset (async assert, sync release):
  - pixel_data = 0; active_src = DEFAULT_SRC; debounced target = DEFAULT_SRC.
  - level = FADE_STEPS; state = SHOW; switching = 0.
  - Synchroniser flops and debounce counter cleared.
- Synchronisation: sel_req and blank_req each pass through a 2-flop synchroniser.
- Raw target (priority encode of the synchronised bits):
  - lowest set sel_req index;
  - else NUM_SRC if blank_req;
  - else DEFAULT_SRC.
- Debounce:
  - Counter resets to 0 whenever the raw target differs from the previous cycle's raw target.
  - Once the raw target has been held for DEB_CYCLES consecutive cycles, the debounced target takes its value.
  - Switch to debounced target latency: 2 sync + DEB_CYCLES cycles.
- frame_start: single-cycle pulse, true when pixel_index == 0 and the registered previous index != 0. No pulse in the first cycle after reset.
- State machine (transitions taken only on frame_start):
  - SHOW: if debounced target != active_src:
    - FADE_EN = 0: active_src <= debounced target; stay in SHOW.
    - FADE_EN = 1: level <= level-1; go to FADE_OUT.
  - FADE_OUT:
    - level > 0: level <= level-1.
    - level == 0: active_src <= debounced target; go to FADE_IN.
    - If the debounced target returns to active_src: go to FADE_IN from the current level, with no source change.
  - FADE_IN:
    - level < FADE_STEPS: level <= level+1.
    - Reaching FADE_STEPS: go to SHOW.
    - If the debounced target differs from active_src: go to FADE_OUT from the current level.
- Pixel path (1-cycle latency from pixel_index/src_data to pixel_data):
  - Selected pixel = src_data slice for active_src; 0 if active_src == NUM_SRC.
  - Scaling: each channel = (chan * level) >> log2(FADE_STEPS), truncating.
  - level == FADE_STEPS passes the pixel unchanged; level == 0 outputs 0x0000.
  - Intermediate products are chan width + log2(FADE_STEPS)+1 bits; no overflow.
- Simultaneous events:
  - active_src, level and state update on the same frame_start edge.
  - pixel_data in that cycle uses the pre-update values.
- Reset mid-fade returns immediately to the reset values above.

Decomposition:
- Shared package oled_pkg: RGB565 field constants (R_MSB/LSB, G_MSB/LSB, B_MSB/LSB), OLED_W = 96, OLED_H = 64, FRAME_PIXELS = 6144, a state enum {SHOW, FADE_OUT, FADE_IN}, and a helper for SEL_W.
- One sub-module, pixel_fader: purely combinational RGB565 channel scaling by level. Instantiated once ahead of the output register.

Test Plan:
- Reset with sel_req = 0, blank_req = 0, src3 = 0xF800 -> pixel_data = 0 during reset, then 0xF800 one cycle after index advances; active_src = 3, switching = 0.
- sel_req = 4'b0110 held (FADE_EN = 1, FADE_STEPS = 4) -> active_src = 1 after 4 frame_start pulses of fade-out.
  - With src3 = 0xFFFF, the fade-out frames show pixel_data = 0xBDF7, 0x7BEF, 0x39E7, 0x0000.
  - Then 4 fade-in frames, then SHOW; switching falls on the last pulse.
- sel_req[0] glitch of 5 cycles (DEB_CYCLES = 8) -> no change to active_src or switching.
- blank_req = 1 with sel_req = 0, FADE_EN = 0 -> active_src = 4 at the next frame_start and pixel_data = 0x0000 from the following cycle; no change mid-frame.
- During FADE_OUT at level 2, drop the request back to the original source -> FADE_IN from level 2, active_src unchanged, SHOW after 2 frames.
- Assert resetn = 0 mid-FADE_IN -> all outputs at reset values within the same cycle, without waiting for a clock edge.
